// File: rtl/noc_pkg.sv
// Shared NoC definitions: op codes, field widths and offsets,
// and the staging flit layout used by injectors and routers.
package noc_pkg;

   localparam int NOC_DST_W   = 4;
   localparam int NOC_VC_W    = 2;
   localparam int NOC_NFLIT_W = 4;
   localparam int NOC_CNT_W   = 8;
   localparam int NOC_DEPTH   = 16;
   localparam int NOC_OP_W    = 4;
   localparam int NOC_DATA_W  = 16;
   localparam int NOC_BUF_W   = 3 + NOC_VC_W + NOC_DST_W;

   localparam logic [3:0] OP_NOP     = 4'd0;
   localparam logic [3:0] OP_INIT    = 4'd1;
   localparam logic [3:0] OP_FILL    = 4'd8;
   localparam logic [3:0] OP_DEQUEUE = 4'd9;

   // Field offsets within FILL data and within the staging flit
   function automatic int d_vc(input int dst_w);
      return dst_w;
   endfunction

   function automatic int d_nflit(input int dst_w, input int vc_w);
      return dst_w + vc_w;
   endfunction

   localparam int B_FULL = 0;
   localparam int B_VC   = 1;
   localparam int B_HEAD = 1 + NOC_VC_W;
   localparam int B_TAIL = 2 + NOC_VC_W;
   localparam int B_DST  = 3 + NOC_VC_W;

   typedef struct packed {
      logic [NOC_DST_W-1:0] dst;
      logic                 tail;
      logic                 head;
      logic [NOC_VC_W-1:0]  vc;
      logic                 full;
   } flit_t;

endpackage

// File: rtl/traffic_injector_if.sv
// Command bus and injection-port view of a traffic injector.
interface traffic_injector_if #(
   parameter int OP_W   = 4,
   parameter int DATA_W = 16,
   parameter int BUF_W  = 9
);
   logic [OP_W-1:0]   op;
   logic [DATA_W-1:0] data;
   logic              done;
   logic [BUF_W-1:0]  buffer;

   modport master (output op, output data, input done, input buffer);
   modport slave  (input op, input data, output done, output buffer);
endinterface

// File: rtl/sync_fifo.sv
// Synchronous descriptor FIFO with push, pop and flush.
module sync_fifo #(
   parameter int W     = 10,
   parameter int DEPTH = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         flush,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic [AW:0]   cnt;
   logic          do_push, do_pop;

   assign full    = cnt == (AW+1)'(DEPTH);
   assign empty   = cnt == '0;
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;
   assign dout    = mem[rp];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else if (flush) begin
         wp  <= '0;
         rp  <= '0;
         cnt <= '0;
      end else begin
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= din;
   end
endmodule

// File: rtl/traffic_injector.sv
// Per-router packet source: queues descriptors and presents
// one flit per DEQUEUE on the injection staging buffer.
module traffic_injector
   import noc_pkg::*;
#(
   parameter int DST_W   = NOC_DST_W,
   parameter int VC_W    = NOC_VC_W,
   parameter int NFLIT_W = NOC_NFLIT_W,
   parameter int CNT_W   = NOC_CNT_W,
   parameter int DEPTH   = NOC_DEPTH,
   parameter int OP_W    = NOC_OP_W,
   parameter int DATA_W  = NOC_DATA_W
) (
   input logic             clk,
   input logic             rst_n,
   traffic_injector_if.slave bus
);
   localparam int DESC_W = DST_W + VC_W + NFLIT_W;
   localparam int DV     = d_vc(DST_W);
   localparam int DN     = d_nflit(DST_W, VC_W);

   logic               is_init, is_fill, is_deq;
   logic               push, pop, full, empty, valid;
   logic [DESC_W-1:0]  fill_desc, head_desc;
   logic [NFLIT_W-1:0] fill_nf, nf, idx;
   logic [DST_W-1:0]   dst;
   logic [VC_W-1:0]    vc;
   logic [CNT_W-1:0]   total, sent;
   logic               armed, head, tail;
   logic               unused_data;

   assign is_init = bus.op == OP_W'(OP_INIT);
   assign is_fill = bus.op == OP_W'(OP_FILL);
   assign is_deq  = bus.op == OP_W'(OP_DEQUEUE);

   // A zero-length packet still carries one flit
   assign fill_nf   = bus.data[DN+:NFLIT_W];
   assign fill_desc = {(fill_nf == '0) ? NFLIT_W'(1) : fill_nf,
                       bus.data[DV+:VC_W], bus.data[0+:DST_W]};
   assign unused_data = ^bus.data;

   assign dst   = head_desc[0+:DST_W];
   assign vc    = head_desc[DV+:VC_W];
   assign nf    = head_desc[DN+:NFLIT_W];
   assign valid = !empty;
   assign head  = idx == '0;
   assign tail  = idx == nf - NFLIT_W'(1);
   assign push  = is_fill;
   assign pop   = is_deq && valid && tail;

   sync_fifo #(.W(DESC_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (is_init),
      .din   (fill_desc),
      .dout  (head_desc),
      .full  (full),
      .empty (empty)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         total <= '0;
         sent  <= '0;
         idx   <= '0;
         armed <= 1'b0;
      end else begin
         unique case (1'b1)
            is_init: begin
               total <= bus.data[CNT_W-1:0];
               sent  <= '0;
               idx   <= '0;
               armed <= 1'b1;
            end
            is_deq && valid: begin
               if (tail) begin
                  idx  <= '0;
                  sent <= (&sent) ? sent : sent + 1'b1;
               end else begin
                  idx  <= idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.done   = armed && empty && (sent >= total);
   assign bus.buffer = valid ? {dst, tail, head, vc, 1'b1} : '0;
endmodule

// File: tb/tb_traffic_injector.sv
// Scoreboard bench for traffic_injector against a queue-based packet model.
module tb_traffic_injector;
   import noc_pkg::*;

   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   traffic_injector_if bus ();

   traffic_injector dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      int dst;
      int vc;
      int nf;
   } pkt_t;

   typedef struct {
      logic [8:0] bfr;
      logic       dn;
   } exp_t;

   pkt_t mq[$];
   exp_t sb[$];
   int   m_idx, m_total, m_sent;
   bit   m_armed;
   int   compared = 0;
   int   mismatched = 0;

   task automatic chk(input string name, input int act, input int exp);
      compared++;
      if (act != exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      mq.delete();
      m_idx = 0;
      m_total = 0;
      m_sent = 0;
      m_armed = 0;
   endfunction

   function automatic logic [8:0] model_buf();
      pkt_t p;
      int   v;
      if (mq.size() == 0) return 9'd0;
      p = mq[0];
      v = p.dst * 32 + ((m_idx == p.nf - 1) ? 16 : 0) +
          ((m_idx == 0) ? 8 : 0) + p.vc * 2 + 1;
      return 9'(v);
   endfunction

   function automatic logic model_done();
      return m_armed && mq.size() == 0 && m_sent >= m_total;
   endfunction

   function automatic void model_step(input int o, input int d);
      pkt_t p;
      if (o == 1) begin
         mq.delete();
         m_total = d % 256;
         m_sent = 0;
         m_idx = 0;
         m_armed = 1;
      end else if (o == 8) begin
         p.dst = d % 16;
         p.vc  = (d / 16) % 4;
         p.nf  = (d / 64) % 16;
         if (p.nf == 0) p.nf = 1;
         if (mq.size() < DEPTH) mq.push_back(p);
      end else if (o == 9 && mq.size() > 0) begin
         if (m_idx == mq[0].nf - 1) begin
            void'(mq.pop_front());
            m_idx = 0;
            if (m_sent < 255) m_sent++;
         end else begin
            m_idx++;
         end
      end
   endfunction

   task automatic issue(input int o, input int d);
      exp_t e;
      @(negedge clk);
      bus.op = 4'(o);
      bus.data = 16'(d);
      model_step(o, d);
      e.bfr = model_buf();
      e.dn = model_done();
      sb.push_back(e);
   endtask

   function automatic int fill_word(input int dst, input int vc, input int nf);
      return dst + vc * 16 + nf * 64;
   endfunction

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (rst_n && sb.size() > 0) begin
            e = sb.pop_front();
            chk("buffer", int'(bus.buffer), int'(e.bfr));
            chk("done", int'(bus.done), int'(e.dn));
         end
      end
   end

   task automatic reset_mid();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      bus.op = 4'(OP_NOP);
      #1;
      chk("rst_mid_buffer", int'(bus.buffer), 0);
      chk("rst_mid_done", int'(bus.done), 0);
      model_reset();
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int r, wait_cnt;
      bus.op = '0;
      bus.data = '0;
      model_reset();
      #12;
      chk("reset_buffer", int'(bus.buffer), 0);
      chk("reset_done", int'(bus.done), 0);
      @(negedge clk);
      rst_n = 1'b1;

      issue(1, 0);
      issue(0, 0);
      issue(1, 2);
      issue(8, fill_word(3, 1, 1));
      issue(9, 0);
      issue(0, 0);
      issue(8, fill_word(5, 0, 3));
      repeat (3) issue(9, 0);
      issue(0, 0);

      issue(1, 200);
      for (int i = 0; i <= DEPTH; i++)
         issue(8, fill_word(i % 16, i % 4, i % 3));
      while (mq.size() > 0) issue(9, 0);
      repeat (3) issue(9, 0);

      issue(1, 3);
      issue(8, fill_word(9, 2, 4));
      issue(9, 0);
      reset_mid();

      for (int n = 0; n < 1500; n++) begin
         r = $urandom_range(0, 99);
         if (r < 8) issue(1, $urandom_range(0, 6));
         else if (r < 45) issue(8, $urandom_range(0, 65535));
         else if (r < 88) issue(9, 0);
         else issue($urandom_range(0, 15), $urandom_range(0, 65535));
         if (n == 700) reset_mid();
      end

      wait_cnt = 0;
      while (sb.size() > 0 && wait_cnt < 10) begin
         @(posedge clk);
         wait_cnt++;
      end
      #2;
      if (sb.size() > 0) begin
         mismatched++;
         $display("FAIL drain: %0d entries left, expected 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
